// File: rtl/paddle_motion.sv
// Paddle position controller: three-state direction FSM with clamped stepping.
// Optional speed ramp while a direction is held, enabled by defining PADDLE_ACCEL_EN.
module paddle_motion #(
  parameter int POS_W       = 10,
  parameter int MAX_SPEED   = 4,
  parameter int ACCEL_TICKS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pause,
  input  logic             tick,
  input  logic             move_left,
  input  logic             move_right,
  input  logic [POS_W-1:0] x_initial,
  input  logic [POS_W-1:0] screen_width,
  input  logic [POS_W-1:0] paddle_width,
  output logic [POS_W-1:0] x_pos,
  output logic [3:0]       speed,
  output logic             at_left,
  output logic             at_right,
  output logic             moving
);

  if (MAX_SPEED < 1 || MAX_SPEED > 15 || ACCEL_TICKS < 1 || ACCEL_TICKS > 255) begin : g_bad_params
    $error("paddle_motion: MAX_SPEED must be 1..15 and ACCEL_TICKS 1..255");
  end

  typedef enum logic [1:0] {IDLE, MOVE_L, MOVE_R} state_t;

  state_t           state_q, state_d;
  logic [POS_W-1:0] right_limit, x_reset;
  logic [POS_W-1:0] x_pos_q, x_pos_d, moved;
  logic [POS_W:0]   sum_r;
  logic [3:0]       speed_q, speed_d, step;
  logic             at_left_q, at_left_d, at_right_q, at_right_d;
  logic             adv, entering;

`ifdef PADDLE_ACCEL_EN
  localparam logic [7:0] HOLD_LAST = 8'(ACCEL_TICKS - 1);
  localparam logic [3:0] SPEED_CAP = 4'(MAX_SPEED);
  logic [7:0] hold_q, hold_d, hold_inc;
`endif

  always_comb begin
    right_limit = (paddle_width < screen_width) ? screen_width - paddle_width : '0;
    x_reset     = (x_initial > right_limit) ? right_limit : x_initial;
    adv         = tick & ~pause;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (adv) begin
      unique case ({move_left, move_right})
        2'b10:   state_d = MOVE_L;
        2'b01:   state_d = MOVE_R;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    moving = (state_q != IDLE);
  end

  // Datapath: step, clamp and speed update for the tick being evaluated
  always_comb begin
    entering = (state_d != state_q);
    step     = entering ? 4'd1 : speed_q;
    sum_r    = '0;
    moved    = x_pos_q;
    x_pos_d  = x_pos_q;
    speed_d  = speed_q;
`ifdef PADDLE_ACCEL_EN
    hold_d   = hold_q;
    hold_inc = hold_q + 8'd1;
`endif
    if (adv) begin
      unique case (state_d)
        MOVE_L: moved = (x_pos_q >= POS_W'(step)) ? x_pos_q - POS_W'(step) : '0;
        MOVE_R: begin
          sum_r = {1'b0, x_pos_q} + (POS_W+1)'(step);
          moved = (sum_r <= {1'b0, right_limit}) ? sum_r[POS_W-1:0] : right_limit;
        end
        default: moved = x_pos_q;
      endcase
      // Final clamp also pulls x_pos in after the geometry shrinks the travel range.
      x_pos_d = (moved > right_limit) ? right_limit : moved;

      if (state_d == IDLE) begin
        speed_d = 4'd0;
`ifdef PADDLE_ACCEL_EN
        hold_d  = '0;
`endif
      end else if (entering) begin
        speed_d = 4'd1;
`ifdef PADDLE_ACCEL_EN
        hold_d  = '0;
`endif
      end else begin
`ifdef PADDLE_ACCEL_EN
        // hold_q is ticks-at-this-speed minus one; reloading all-ones after a
        // speed-up makes the next tick count as the first at the new speed.
        if (hold_inc >= HOLD_LAST) begin
          hold_d = '1;
          if (speed_q < SPEED_CAP) speed_d = speed_q + 4'd1;
        end else begin
          hold_d = hold_inc;
        end
`else
        speed_d = 4'd1;
`endif
      end
    end
    at_left_d  = adv ? (x_pos_d == '0)          : at_left_q;
    at_right_d = adv ? (x_pos_d == right_limit) : at_right_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_pos_q    <= x_reset;
      speed_q    <= '0;
      at_left_q  <= (x_reset == '0);
      at_right_q <= (x_reset == right_limit);
`ifdef PADDLE_ACCEL_EN
      hold_q     <= '0;
`endif
    end else begin
      x_pos_q    <= x_pos_d;
      speed_q    <= speed_d;
      at_left_q  <= at_left_d;
      at_right_q <= at_right_d;
`ifdef PADDLE_ACCEL_EN
      hold_q     <= hold_d;
`endif
    end
  end

  always_comb begin
    x_pos    = x_pos_q;
    speed    = speed_q;
    at_left  = at_left_q;
    at_right = at_right_q;
  end

endmodule
